// File: rtl/rs_io_pkg.sv
// rtl/rs_io_pkg.sv - shared types and helpers for the redstone host link
package rs_io_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    CNT_LO,
    CNT_HI,
    PAYLOAD,
    CSUM
  } rs_state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Two 4-bit nodes are packed per payload byte.
  function automatic int payload_bytes(input int num_outputs);
    return (num_outputs + 1) / 2;
  endfunction

endpackage

// File: rtl/rs_output_tx_if.sv
// rtl/rs_output_tx_if.sv - byte stream from the fabric to the host bridge
interface rs_output_tx_if;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;

  modport master (output o_data, output o_valid, input i_ready);
  modport slave  (input o_data, input o_valid, output i_ready);
endinterface

// File: rtl/rs_snapshot_mux.sv
// rtl/rs_snapshot_mux.sv - snapshot register and payload byte selector
module rs_snapshot_mux
  import rs_io_pkg::*;
#(
  parameter int  NUM_OUTPUTS = 16,
  localparam int PB          = payload_bytes(NUM_OUTPUTS),
  localparam int IDX_W       = (PB > 1) ? $clog2(PB) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     capture,
  input  logic [NUM_OUTPUTS*4-1:0] nodes,
  input  logic [15:0]              count_in,
  input  logic [IDX_W-1:0]         sel,
  output logic [15:0]              count,
  output logic [7:0]               payload_byte
);

  localparam int SNAP_W = PB * 8;

  logic [SNAP_W-1:0] snap;

  // Zero-extension supplies the 4'h0 high nibble when NUM_OUTPUTS is odd.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap  <= '0;
      count <= '0;
    end else if (capture) begin
      snap  <= SNAP_W'(nodes);
      count <= count_in;
    end
  end

  assign payload_byte = snap[sel*8 +: 8];

endmodule

// File: rtl/rs_output_tx.sv
// rtl/rs_output_tx.sv - per-tick snapshot framer streaming output strengths to the host
module rs_output_tx
  import rs_io_pkg::*;
#(
  parameter int         NUM_OUTPUTS = 16,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_tick,
  input  logic [NUM_OUTPUTS*4-1:0] i_outputs,
  rs_output_tx_if.master           tx,
  output logic                     o_busy,
  output logic [7:0]               o_drop_cnt
);

  localparam int               PB       = payload_bytes(NUM_OUTPUTS);
  localparam int               IDX_W    = (PB > 1) ? $clog2(PB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PB - 1);

  rs_state_e        state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] sel;
  logic [15:0]      tick_cnt;
  logic [15:0]      snap_cnt;
  logic [7:0]       payload_byte;
  logic [7:0]       csum;
  logic             hs;
  logic             capture;
  logic             drop;

  assign hs      = tx.o_valid && tx.i_ready;
  assign capture = i_tick && (state == IDLE || (state == CSUM && hs));
  assign drop    = i_tick && !capture;

  // Look one byte ahead so o_data can be loaded on the handshake edge.
  always_comb begin
    sel = '0;
    if (state == PAYLOAD && idx != LAST_IDX) sel = idx + 1'b1;
  end

  rs_snapshot_mux #(.NUM_OUTPUTS(NUM_OUTPUTS)) u_snapshot_mux (
    .clk          (i_clk),
    .rst_n        (i_rst_n),
    .capture      (capture),
    .nodes        (i_outputs),
    .count_in     (tick_cnt),
    .sel          (sel),
    .count        (snap_cnt),
    .payload_byte (payload_byte)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      tick_cnt   <= '0;
      csum       <= '0;
      tx.o_data  <= '0;
      tx.o_valid <= 1'b0;
      o_busy     <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      if (i_tick) tick_cnt <= tick_cnt + 16'd1;
      if (drop && o_drop_cnt != 8'hFF) o_drop_cnt <= o_drop_cnt + 8'd1;

      case (state)
        IDLE: begin
          if (i_tick) begin
            state      <= SYNC;
            tx.o_data  <= SYNC_BYTE;
            tx.o_valid <= 1'b1;
            o_busy     <= 1'b1;
            csum       <= '0;
          end
        end
        SYNC: begin
          if (hs) begin
            state     <= CNT_LO;
            tx.o_data <= snap_cnt[7:0];
          end
        end
        CNT_LO: begin
          if (hs) begin
            state     <= CNT_HI;
            tx.o_data <= snap_cnt[15:8];
            csum      <= csum ^ tx.o_data;
          end
        end
        CNT_HI: begin
          if (hs) begin
            state     <= PAYLOAD;
            idx       <= '0;
            tx.o_data <= payload_byte;
            csum      <= csum ^ tx.o_data;
          end
        end
        PAYLOAD: begin
          if (hs) begin
            csum <= csum ^ tx.o_data;
            if (idx == LAST_IDX) begin
              state     <= CSUM;
              tx.o_data <= csum ^ tx.o_data;
            end else begin
              idx       <= idx + 1'b1;
              tx.o_data <= payload_byte;
            end
          end
        end
        CSUM: begin
          if (hs) begin
            if (i_tick) begin
              state     <= SYNC;
              tx.o_data <= SYNC_BYTE;
              csum      <= '0;
            end else begin
              state      <= IDLE;
              tx.o_data  <= '0;
              tx.o_valid <= 1'b0;
              o_busy     <= 1'b0;
            end
          end
        end
        default: begin
          state      <= IDLE;
          tx.o_valid <= 1'b0;
          o_busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
